// File: rtl/ramb_asym_dp_pkg.sv
// Shared types and helpers for the asymmetric dual-port block RAM.
package ramb_asym_pkg;

   typedef enum logic [1:0] {
      WRITE_FIRST = 2'd0,
      READ_FIRST  = 2'd1,
      NO_CHANGE   = 2'd2
   } write_mode_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Two half-open bit ranges [lo, lo+w) intersect when each starts before the other ends.
   function automatic logic ranges_overlap(input int lo_a, input int w_a,
                                           input int lo_b, input int w_b);
      return (lo_a < lo_b + w_b) && (lo_b < lo_a + w_a);
   endfunction

endpackage

// File: rtl/ramb_asym_dp_if.sv
// Bus bundle for both ports of ramb_asym_dp; address widths derive from the array size.
interface ramb_asym_dp_if
   import ramb_asym_pkg::*;
#(
   parameter int MEM_BITS = 16384,
   parameter int WIDTH_A  = 1,
   parameter int WIDTH_B  = 4
);
   localparam int AW_A = clog2(MEM_BITS / WIDTH_A);
   localparam int AW_B = clog2(MEM_BITS / WIDTH_B);

   logic               ena, wea, ssra, regcea;
   logic [AW_A-1:0]    addra;
   logic [WIDTH_A-1:0] dia, doa;
   logic               enb, web, ssrb, regceb;
   logic [AW_B-1:0]    addrb;
   logic [WIDTH_B-1:0] dib, dob;
   logic               coll;

   modport master (
      output ena, wea, ssra, regcea, addra, dia,
      output enb, web, ssrb, regceb, addrb, dib,
      input  doa, dob, coll
   );

   modport slave (
      input  ena, wea, ssra, regcea, addra, dia,
      input  enb, web, ssrb, regceb, addrb, dib,
      output doa, dob, coll
   );
endinterface

// File: rtl/ramb_asym_dp_port.sv
// Output path of one RAM port: write-mode mux, SSR/RST priority and the
// optional second output stage enabled by RAMB_ASYM_DP_OUTREG_EN.
module ramb_asym_port
   import ramb_asym_pkg::*;
#(
   parameter int          WIDTH      = 1,
   parameter write_mode_e WRITE_MODE = WRITE_FIRST,
   parameter logic [WIDTH-1:0] INIT  = '0,
   parameter logic [WIDTH-1:0] SRVAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             we,
   input  logic             ssr,
   input  logic             regce,
   input  logic [WIDTH-1:0] di,
   input  logic [WIDTH-1:0] oldWord,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] latchQ;

   // Reset beats SSR, SSR beats the write-mode choice; a plain read always loads the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         latchQ <= INIT;
      end else if (en) begin
         if (ssr) begin
            latchQ <= SRVAL;
         end else if (!we) begin
            latchQ <= oldWord;
         end else begin
            case (WRITE_MODE)
               WRITE_FIRST: latchQ <= di;
               READ_FIRST:  latchQ <= oldWord;
               default:     latchQ <= latchQ;
            endcase
         end
      end
   end

`ifdef RAMB_ASYM_DP_OUTREG_EN
   logic [WIDTH-1:0] outQ;

   // SSR forces the output stage directly so the set/reset value shows without the extra cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         outQ <= INIT;
      end else if (en && ssr) begin
         outQ <= SRVAL;
      end else if (regce) begin
         outQ <= latchQ;
      end
   end

   assign dout = outQ;
`else
   logic unusedRegce;
   assign unusedRegce = regce;
   assign dout        = latchQ;
`endif

endmodule

// File: rtl/ramb_asym_dp.sv
// Single-clock true-dual-port RAM with independent port widths over one bit array.
// Optional output pipeline stage: define RAMB_ASYM_DP_OUTREG_EN.
module ramb_asym_dp
   import ramb_asym_pkg::*;
#(
   parameter int          MEM_BITS     = 16384,
   parameter int          WIDTH_A      = 1,
   parameter int          WIDTH_B      = 4,
   parameter write_mode_e WRITE_MODE_A = WRITE_FIRST,
   parameter write_mode_e WRITE_MODE_B = WRITE_FIRST,
   parameter logic [WIDTH_A-1:0]  INIT_A   = '0,
   parameter logic [WIDTH_B-1:0]  INIT_B   = '0,
   parameter logic [WIDTH_A-1:0]  SRVAL_A  = '0,
   parameter logic [WIDTH_B-1:0]  SRVAL_B  = '0,
   parameter logic [MEM_BITS-1:0] MEM_INIT = '0
) (
   input logic clk,
   input logic rst,
   ramb_asym_dp_if.slave bus
);

   localparam int MB   = clog2(MEM_BITS);
   localparam int LW_A = clog2(WIDTH_A);
   localparam int LW_B = clog2(WIDTH_B);

   // Storage holds contents XOR MEM_INIT, so zero power-up state reads back as MEM_INIT.
   logic [MEM_BITS-1:0] memQ;
   logic [MB-1:0]       loA, loB;
   logic [WIDTH_A-1:0]  oldA;
   logic [WIDTH_B-1:0]  oldB;
   logic                collNow, collQ;

   assign loA  = MB'(bus.addra) << LW_A;
   assign loB  = MB'(bus.addrb) << LW_B;
   assign oldA = memQ[loA +: WIDTH_A] ^ MEM_INIT[loA +: WIDTH_A];
   assign oldB = memQ[loB +: WIDTH_B] ^ MEM_INIT[loB +: WIDTH_B];

   assign collNow = bus.ena && bus.enb && (bus.wea || bus.web) &&
                    ranges_overlap(int'(loA), WIDTH_A, int'(loB), WIDTH_B);

   // Port B is written last so its data wins on any bits both ports hit in the same cycle.
   always_ff @(posedge clk) begin
      if (bus.ena && bus.wea) memQ[loA +: WIDTH_A] <= bus.dia ^ MEM_INIT[loA +: WIDTH_A];
      if (bus.enb && bus.web) memQ[loB +: WIDTH_B] <= bus.dib ^ MEM_INIT[loB +: WIDTH_B];
   end

   always_ff @(posedge clk) begin
      if (rst) collQ <= 1'b0;
      else     collQ <= collNow;
   end

`ifdef RAMB_ASYM_DP_OUTREG_EN
   logic collOutQ;

   // Flag follows port B's output stage so it stays aligned with DOB.
   always_ff @(posedge clk) begin
      if (rst)             collOutQ <= 1'b0;
      else if (bus.regceb) collOutQ <= collQ;
   end

   assign bus.coll = collOutQ;
`else
   assign bus.coll = collQ;
`endif

   ramb_asym_port #(
      .WIDTH(WIDTH_A), .WRITE_MODE(WRITE_MODE_A), .INIT(INIT_A), .SRVAL(SRVAL_A)
   ) portA (
      .clk(clk), .rst(rst), .en(bus.ena), .we(bus.wea), .ssr(bus.ssra),
      .regce(bus.regcea), .di(bus.dia), .oldWord(oldA), .dout(bus.doa)
   );

   ramb_asym_port #(
      .WIDTH(WIDTH_B), .WRITE_MODE(WRITE_MODE_B), .INIT(INIT_B), .SRVAL(SRVAL_B)
   ) portB (
      .clk(clk), .rst(rst), .en(bus.enb), .we(bus.web), .ssr(bus.ssrb),
      .regce(bus.regceb), .di(bus.dib), .oldWord(oldB), .dout(bus.dob)
   );

endmodule

// File: doc/ramb_asym_dp.md
Name: ramb_asym_dp

Overview:
Parametrised single-clock true-dual-port block RAM with independent port widths over one shared bit array. It generalises the fixed-geometry RAMB16_Sx_Sy primitives to any power-of-two aspect ratio and memory size. It adds per-port write modes, deterministic collision resolution with a collision flag, and an optional output pipeline register. It sits in the unisims library beside the fixed primitives, and wrappers and FIFOs instantiate it directly.

Parameters:
MEM_BITS, 16384, total data bits in the array; must be a power of two.
WIDTH_A, 1, port A data width; power of two, 1..MEM_BITS.
WIDTH_B, 4, port B data width; power of two, 1..MEM_BITS.
WRITE_MODE_A, "WRITE_FIRST", port A mode: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
WRITE_MODE_B, "WRITE_FIRST", port B write mode; same encoding as port A.
INIT_A, 0, DOA value after RST (WIDTH_A bits).
INIT_B, 0, DOB value after RST (WIDTH_B bits).
SRVAL_A, 0, DOA value loaded by SSRA (WIDTH_A bits).
SRVAL_B, 0, DOB value loaded by SSRB (WIDTH_B bits).
MEM_INIT, 0, initial array contents; MEM_BITS wide; bit i is array bit i.
Derived: AW_A = clog2(MEM_BITS/WIDTH_A); AW_B = clog2(MEM_BITS/WIDTH_B).

Ports:
CLK  in  1  single clock for both ports; all logic on rising edge
RST  in  1  synchronous, active-high reset
ENA  in  1  port A enable; gates every port A action
WEA  in  1  port A write enable, qualified by ENA
SSRA  in  1  port A synchronous output set/reset, qualified by ENA
ADDRA  in  AW_A  port A word address
DIA  in  WIDTH_A  port A write data
DOA  out  WIDTH_A  port A read data
REGCEA  in  1  port A output-register clock enable (used only with optional feature)
ENB, WEB, SSRB, ADDRB[AW_B], DIB[WIDTH_B], DOB[WIDTH_B], REGCEB  same roles for port B
COLL  out  1  collision flag, aligned with the read data of the colliding cycle

Behaviour:
- Bit mapping: port word at address a occupies array bits [a*W +: W], where W is that port's width.
- RST: DOA <= INIT_A, DOB <= INIT_B, COLL <= 0. The array is not cleared. RST overrides EN and SSR in the same cycle.
- Port disabled (EN=0): DO holds its value; no write takes place.
- Read latency is 1 cycle. DO updates on the edge after EN is sampled high.
- SSR=1 with EN=1: DO <= SRVAL. If WE=1, the write to the array still happens.
- Write with EN=1, WE=1, SSR=0:
  - WRITE_FIRST: DO <= DI.
  - READ_FIRST: DO <= old word.
  - NO_CHANGE: DO holds its value.
- Overlap: both ports enabled and their bit ranges intersect. Port A range is [ADDRA*WIDTH_A +: WIDTH_A]; port B range is [ADDRB*WIDTH_B +: WIDTH_B].
- Write/write overlap: port B data wins on the overlapping bits. Non-overlapping bits of port A's word are written normally. COLL=1.
- Write/read overlap: the reading port returns pre-write contents for the overlapping bits. The writing port follows its own write mode. COLL=1.
- Read/read overlap: no collision; COLL=0.
- COLL is a 1-cycle pulse, registered alongside DO. It is 0 in any cycle with no collision.
- Address range is always in bounds by construction of AW; no wrap logic is needed.

Optional Feature:
Macro RAMB_ASYM_DP_OUTREG_EN.
- Defined:
  - Adds a second output register stage per port; read latency becomes 2.
  - The stage loads only when REGCEx=1; otherwise it holds.
  - SSRx and RST also set the output stage to SRVAL / INIT.
  - COLL is delayed to match port B's output stage.
- Undefined: REGCEA and REGCEB are ignored and latency is 1.

Decomposition:
- Package ramb_asym_pkg contains:
  - write_mode_e enum (WRITE_FIRST, READ_FIRST, NO_CHANGE);
  - a clog2 function;
  - a range-overlap function (lo_a, w_a, lo_b, w_b).
- Sub-module ramb_asym_port, instantiated once per port. It contains the output latch, write-mode mux, SSR/RST priority and the optional output register. Array storage and collision arbitration stay in the top module.

Test Plan:
- Defaults (WIDTH_A=1, WIDTH_B=4): write B ADDRB=0x003, DIB=4'hA; then read A at 12, 13, 14, 15 -> DOA = 0, 1, 0, 1.
- Write A ADDRA=0x0005, DIA=1 in WRITE_FIRST -> DOA=1 next cycle. Repeat with READ_FIRST over a 0 -> DOA=0. Repeat with NO_CHANGE -> DOA unchanged.
- Same cycle: A writes 1 at addr 8, B writes 4'h0 at addr 2 -> COLL=1 one cycle later; A re-read at 8 returns 0 (port B wins).
- Same cycle: B reads addr 2 (old contents 4'h0), A writes 1 at addr 9 -> DOB=4'h0, COLL=1. Next B read returns 4'h2.
- SSRB=1 with WEB=1, DIB=4'h7, SRVAL_B=4'h5 -> DOB=4'h5; a later read returns 4'h7. RST mid-stream -> DOA=INIT_A, DOB=INIT_B, COLL=0, array contents retained.
- With RAMB_ASYM_DP_OUTREG_EN: data appears 2 cycles after the read. With REGCEB=0, DOB holds; asserting REGCEB=1 releases it.
